// File: rtl/color_fsm_decoder.sv
//------------------------------------------------------------------------------
// color_fsm_decoder
//
// Receive-side inverse of the two-state Color Mealy encoder (Blue=0, Red=1,
// reset state Red). Each accepted 2-bit encoder output symbol is mapped back
// to the encoder input symbol that produced it, using a mirror copy of the
// encoder state. Symbols the encoder cannot emit from the mirror state are
// dropped, flagged with a one-cycle err pulse and counted.
//
// Optional build macro:
//   COLOR_FSM_DECODER_RESYNC_EN - when defined, an illegal symbol forces the
//                                 mirror state back to Red (encoder reset
//                                 state); otherwise the mirror state holds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   sym_valid  in   encoder symbol present on sym
//   sym        in   [1:0] encoder output symbol
//   sym_ready  out  decoder can accept sym this cycle
//   dec_valid  out  reconstructed symbol present on dec_in
//   dec_in     out  [1:0] reconstructed encoder input
//   dec_ready  in   downstream consumes dec_in this cycle
//   state      out  mirror state (0=Blue, 1=Red)
//   err        out  one-cycle pulse after an illegal symbol
//   err_clr    in   clears err_count
//   err_count  out  [CNT_WIDTH-1:0] saturating illegal-symbol count
//------------------------------------------------------------------------------
module color_fsm_decoder #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sym_valid,
   input  logic [1:0]           sym,
   output logic                 sym_ready,
   output logic                 dec_valid,
   output logic [1:0]           dec_in,
   input  logic                 dec_ready,
   output logic                 state,
   output logic                 err,
   input  logic                 err_clr,
   output logic [CNT_WIDTH-1:0] err_count
);

   typedef enum logic {
      ST_BLUE = 1'b0,
      ST_RED  = 1'b1
   } color_e;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   color_e                 state_q, state_d;
   logic                   dec_valid_q, dec_valid_d;
   logic [1:0]             dec_in_q, dec_in_d;
   logic                   err_q, err_d;
   logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;

   logic                   accept_s;
   logic                   legal_s;
   logic [1:0]             dec_val_s;
   color_e                 next_state_s;
   logic [CNT_WIDTH-1:0]   cnt_base_s;

   // Single output register: a new symbol fits if the slot is empty or drains now.
   assign sym_ready = !dec_valid_q || dec_ready;
   assign accept_s  = sym_valid && sym_ready;

   // Inverse encoder table: legality, reconstructed input and next mirror state.
   always_comb begin
      legal_s      = 1'b0;
      dec_val_s    = 2'h0;
      next_state_s = state_q;
      case ({state_q, sym})
         {ST_RED, 2'h2}: begin
            legal_s      = 1'b1;
            dec_val_s    = 2'h0;
            next_state_s = ST_RED;
         end
         {ST_RED, 2'h1}: begin
            legal_s      = 1'b1;
            dec_val_s    = 2'h1;
            next_state_s = ST_BLUE;
         end
         {ST_BLUE, 2'h2}: begin
            legal_s      = 1'b1;
            dec_val_s    = 2'h1;
            next_state_s = ST_RED;
         end
         default: begin
            legal_s      = 1'b0;
            dec_val_s    = 2'h0;
            next_state_s = state_q;
         end
      endcase
   end

   // Next-state logic for mirror state, output slot, error pulse and counter.
   always_comb begin
      state_d     = state_q;
      dec_valid_d = dec_valid_q;
      dec_in_d    = dec_in_q;
      err_d       = 1'b0;

      // Clear is applied before a same-cycle increment.
      if (err_clr) begin
         cnt_base_s = '0;
      end else begin
         cnt_base_s = err_count_q;
      end
      err_count_d = cnt_base_s;

      if (accept_s && legal_s) begin
         state_d     = next_state_s;
         dec_valid_d = 1'b1;
         dec_in_d    = dec_val_s;
      end else if (accept_s) begin
         err_d = 1'b1;
`ifdef COLOR_FSM_DECODER_RESYNC_EN
         state_d = ST_RED;
`else
         state_d = state_q;
`endif
         if (cnt_base_s != CNT_MAX) begin
            err_count_d = cnt_base_s + CNT_WIDTH'(1);
         end else begin
            err_count_d = cnt_base_s;
         end
         // An illegal accept only happens with a free slot; drain it if consumed.
         if (dec_valid_q && dec_ready) begin
            dec_valid_d = 1'b0;
         end else begin
            dec_valid_d = dec_valid_q;
         end
      end else if (dec_valid_q && dec_ready) begin
         dec_valid_d = 1'b0;
      end else begin
         dec_valid_d = dec_valid_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RED;
         dec_valid_q <= 1'b0;
         dec_in_q    <= 2'h0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         dec_valid_q <= dec_valid_d;
         dec_in_q    <= dec_in_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   assign state     = state_q;
   assign dec_valid = dec_valid_q;
   assign dec_in    = dec_in_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule

// File: doc/color_fsm_decoder.md
Name: color_fsm_decoder

Overview:
- Receive-side inverse of the two-state Color Mealy encoder (states Blue=1'h0, Red=1'h1; reset state Red).
- Consumes the encoder's 2-bit output symbol stream over a valid/ready handshake.
- Tracks a mirror copy of the encoder state and reconstructs the original 2-bit input symbol for each received symbol.
- Flags, drops and counts symbols that the encoder cannot legally emit from the current mirror state; sits directly downstream of the encoder link.

Parameters:
- CNT_WIDTH, 8, width of the saturating protocol-error counter (>=1).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sym_valid  input  1  encoder symbol present on sym.
- sym  input  2  encoder output symbol.
- sym_ready  output  1  decoder can accept sym this cycle.
- dec_valid  output  1  reconstructed input symbol present on dec_in.
- dec_in  output  2  reconstructed encoder input value.
- dec_ready  input  1  downstream accepts dec_in this cycle.
- state  output  1  mirror state (0=Blue, 1=Red).
- err  output  1  one-cycle pulse on an illegal symbol.
- err_clr  input  1  clears err_count.
- err_count  output  CNT_WIDTH  saturating count of illegal symbols.

Behaviour:
- Reset (rst=1 at a clk edge): state=Red(1), dec_valid=0, dec_in=2'h0, err=0, err_count=0. sym_ready is 1 on the first cycle after reset. Reset asserted mid-operation discards any held dec_in.
- Handshakes:
  - A symbol is accepted when sym_valid && sym_ready.
  - A result is consumed when dec_valid && dec_ready.
  - sym_ready = !dec_valid || dec_ready (single output register, combinational ready path). Accept and consume may happen in the same cycle.
- Decode table, applied to the mirror state at accept:
  - Red, sym=2'h2 -> dec_in=2'h0, next state Red.
  - Red, sym=2'h1 -> dec_in=2'h1, next state Blue.
  - Blue, sym=2'h2 -> dec_in=2'h1, next state Red.
  - Anything else (sym=2'h0, sym=2'h3, Blue with sym=2'h1) is illegal.
- Latency: a legal accept in cycle N gives dec_valid=1 and a valid dec_in in cycle N+1. state updates at the same edge.
- dec_valid/dec_in hold stable until consumed. dec_valid drops the cycle after consume, unless a new legal symbol was accepted in the same cycle.
- Illegal accept:
  - The symbol is consumed (sym_ready behaviour is unchanged) and produces no dec_valid.
  - err=1 for exactly the next cycle.
  - err_count increments and saturates at 2^CNT_WIDTH-1.
  - Mirror state handling depends on the optional feature.
- err_clr: err_count=0 at the next edge. If an illegal accept occurs in the same cycle, clear takes effect first and the increment still applies, so err_count=1.
- sym_valid=0: no state change. dec_valid drains normally.

Optional Feature:
- Macro: COLOR_FSM_DECODER_RESYNC_EN.
- Defined: on an illegal accept, the mirror state is forced to Red, so the decoder realigns to the encoder's reset state.
- Not defined: on an illegal accept, the mirror state is unchanged.
- Error pulse and counting are identical in both builds.

Test Plan:
- Legal stream: reset, then sym=2,1,2,1 with dec_ready=1 -> dec_in=0,1,1,1, each one cycle after accept; state sequence Red,Blue,Red,Blue; err never asserted; err_count=0.
- Illegal in Blue: after state=Blue, send sym=1 -> err pulses 1 cycle, err_count=1, no dec_valid. Without the macro state stays 0; with the macro state becomes 1.
- Backpressure: dec_ready=0, send sym=2 then sym=1 -> first accepted (dec_in=0 held), sym_ready=0 and the second held. Raise dec_ready -> dec_in=0 consumed, sym=1 accepted the same cycle, next cycle dec_in=1 and state=Blue.
- Saturation and clear: CNT_WIDTH=2, five illegal syms (sym=3) -> err_count=3. err_clr together with a sixth illegal sym -> err_count=1.
- Reset mid-operation: dec_valid=1 held with dec_ready=0 and state=Blue, then rst=1 for one cycle -> dec_valid=0, state=1, err_count=0, sym_ready=1.
